// File: rtl/adain_pkg.sv
// Shared definitions for the AdaIN shift-amount path.
//   - default widths (pixel count, MAC word, fractional bits)
//   - phase codes driven to the shift-amount generator
//   - fixed shift constants used by the inverse-sqrt stage
//   - is_pow2 helper used to validate the pixel count
package adain_pkg;

  localparam int N_MAX        = 256;
  localparam int WIDTH_MAC_IN = 48;
  localparam int FRAC_BITS_IN = 16;

  // Phase codes are decoded directly by the shift-amount generator.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_MEAN = 3'b001,
    ST_VAR  = 3'b010,
    ST_ISQ  = 3'b011,
    ST_LZC  = 3'b100,
    ST_DONE = 3'b101
  } state_e;

  localparam int INVSQRT_SHIFT_IN  = WIDTH_MAC_IN - 2;
  localparam int INVSQRT_SHIFT_OUT = (2*WIDTH_MAC_IN - 3*FRAC_BITS_IN - 6) >> 1;

  function automatic logic is_pow2(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/lzc_iter.sv
// Iterative leading-zero counter, one binary-search halving step per cycle.
// The word is zero-padded on the right to PW = 2^LZW bits, so the count of a
// nonzero word equals its true leading-zero count; an all-zero word yields PW-1.
// The first halving step is applied on the start edge, so the result is ready
// (done=1, count valid) in the LZW-th cycle after start.
//   clk, rst   clock / async active-high reset
//   clr        cancel an in-flight count
//   start      load din and begin (overrides any in-flight count)
//   din        word to count
//   busy       search in progress
//   done       1-cycle pulse, count valid in that cycle
//   count      leading-zero count (unclamped)
module lzc_iter #(
  parameter int W   = 48,
  parameter int LZW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           start,
  input  logic [W-1:0]   din,
  output logic           busy,
  output logic           done,
  output logic [LZW-1:0] count
);

  localparam int PW = 1 << LZW;

  logic [PW-1:0]  x, x_src, x_nxt;
  logic [LZW-1:0] cnt_src, cnt_nxt;
  logic [LZW-1:0] step;
  logic           hi_zero;
  int             idx, sh;

  // One halving step: if the top sh bits are all zero, add sh and shift them out.
  always_comb begin
    x_src   = start ? (PW'(din) << (PW - W)) : x;
    cnt_src = start ? '0 : count;
    idx     = start ? 0 : int'(step);
    sh      = PW >> (idx + 1);
    hi_zero = ((x_src >> (PW - sh)) == '0);
    x_nxt   = hi_zero ? (x_src << sh) : x_src;
    cnt_nxt = hi_zero ? (cnt_src + LZW'(sh)) : cnt_src;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x     <= '0;
      count <= '0;
      step  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x     <= x_nxt;
        count <= cnt_nxt;
        step  <= LZW'(1);
        busy  <= 1'b1;
      end else if (clr) begin
        busy <= 1'b0;
      end else if (busy) begin
        x     <= x_nxt;
        count <= cnt_nxt;
        step  <= step + LZW'(1);
        if (step == LZW'(LZW - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adain_shift_ctrl.sv
// AdaIN normalisation sequencer: steps MEAN -> VAR -> LZC -> ISQ -> DONE and
// supplies the shift-amount generator with the phase code, log2(N) and the
// clamped leading-zero count of the variance.
//   clk, rst        clock / async active-high reset
//   start           begin a channel (IDLE only), n_pixels must be a power of two
//   n_pixels        pixel count
//   abort           return to IDLE from any busy state, no done pulse
//   mean_done       mean phase finished (MEAN only)
//   var_valid       var_in valid (VAR only)
//   var_in          unsigned variance
//   invsqrt_done    inverse-sqrt finished (ISQ only)
//   state           phase code
//   lead_zero_N     log2(n_pixels)
//   lead_zero_var   leading zeros of var_in, clamped to WIDTH_MAC_IN-2
//   busy            not IDLE
//   done            1-cycle pulse in DONE
//   err_n           1-cycle pulse on start with a bad n_pixels
//   err_zero_var    sticky flag for var_in==0, cleared by the next accepted start
module adain_shift_ctrl
  import adain_pkg::*;
#(
  parameter int N_MAX        = adain_pkg::N_MAX,
  parameter int WIDTH_MAC_IN = adain_pkg::WIDTH_MAC_IN,
  parameter int FRAC_BITS_IN = adain_pkg::FRAC_BITS_IN,
  parameter int WIDTH_N      = $clog2(N_MAX + 1),
  parameter int LZN          = $clog2(WIDTH_N),
  parameter int LZW          = $clog2(WIDTH_MAC_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH_N-1:0]      n_pixels,
  input  logic                    abort,
  input  logic                    mean_done,
  input  logic                    var_valid,
  input  logic [WIDTH_MAC_IN-1:0] var_in,
  input  logic                    invsqrt_done,
  output logic [2:0]              state,
  output logic [LZN-1:0]          lead_zero_N,
  output logic [LZW-1:0]          lead_zero_var,
  output logic                    busy,
  output logic                    done,
  output logic                    err_n,
  output logic                    err_zero_var
);

  localparam logic [LZW-1:0] LZ_CLAMP = LZW'(WIDTH_MAC_IN - 2);

  state_e         st;
  logic           n_ok;
  logic [LZN-1:0] log2_n;
  logic           lzc_start, lzc_busy, lzc_done;
  logic [LZW-1:0] lzc_count, lz_clamped;

  assign n_ok = is_pow2(32'(n_pixels));

  // MSB index of n_pixels; only meaningful when n_ok.
  always_comb begin
    log2_n = '0;
    for (int i = 0; i < WIDTH_N; i++)
      if (n_pixels[i]) log2_n = LZN'(i);
  end

  // Counter is loaded on the VAR->LZC edge, which is also where var_in is captured.
  assign lzc_start = (st == ST_VAR) && var_valid && !abort;

  lzc_iter #(.W(WIDTH_MAC_IN), .LZW(LZW)) u_lzc (
    .clk   (clk),
    .rst   (rst),
    .clr   (abort),
    .start (lzc_start),
    .din   (var_in),
    .busy  (lzc_busy),
    .done  (lzc_done),
    .count (lzc_count)
  );

  // Clamp keeps the downstream left shift non-negative (also covers var_in==0).
  assign lz_clamped = (lzc_count > LZ_CLAMP) ? LZ_CLAMP : lzc_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_n         <= 1'b0;
      err_zero_var  <= 1'b0;
      lead_zero_N   <= '0;
      lead_zero_var <= '0;
    end else begin
      done  <= 1'b0;
      err_n <= 1'b0;
      if (st != ST_IDLE && abort) begin
        st   <= ST_IDLE;
        busy <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: if (start) begin
            if (n_ok) begin
              st           <= ST_MEAN;
              busy         <= 1'b1;
              lead_zero_N  <= log2_n;
              err_zero_var <= 1'b0;
            end else begin
              err_n <= 1'b1;
            end
          end
          ST_MEAN: if (mean_done) st <= ST_VAR;
          ST_VAR: if (var_valid) begin
            st <= ST_LZC;
            if (var_in == '0) err_zero_var <= 1'b1;
          end
          ST_LZC: if (lzc_done) begin
            st            <= ST_ISQ;
            lead_zero_var <= lz_clamped;
          end
          ST_ISQ: if (invsqrt_done) begin
            st   <= ST_DONE;
            done <= 1'b1;
          end
          ST_DONE: begin
            st   <= ST_IDLE;
            busy <= 1'b0;
          end
          default: begin
            st   <= ST_IDLE;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_adain_shift_ctrl.sv
// Directed bench for adain_shift_ctrl: full channel flow, LZC clamping and
// zero-variance flag, bad pixel counts, ignored inputs, abort, async reset,
// and a one-hot variance sweep.
module tb_adain_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, mean_done, var_valid, invsqrt_done;
  logic [8:0]  n_pixels;
  logic [47:0] var_in;
  logic [2:0]  state;
  logic [3:0]  lead_zero_N;
  logic [5:0]  lead_zero_var;
  logic        busy, done, err_n, err_zero_var;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adain_shift_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .n_pixels     (n_pixels),
    .abort        (abort),
    .mean_done    (mean_done),
    .var_valid    (var_valid),
    .var_in       (var_in),
    .invsqrt_done (invsqrt_done),
    .state        (state),
    .lead_zero_N  (lead_zero_N),
    .lead_zero_var(lead_zero_var),
    .busy         (busy),
    .done         (done),
    .err_n        (err_n),
    .err_zero_var (err_zero_var)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a 256-pixel channel and walk it to ISQ, checking LZC length.
  task automatic go_to_isq(input logic [47:0] v, input string tag);
    int cyc;
    n_pixels = 9'd256; start = 1'b1; tick; start = 1'b0;
    chk({tag, "_mean"}, 64'(state), 64'd1);
    mean_done = 1'b1; tick; mean_done = 1'b0;
    chk({tag, "_var"}, 64'(state), 64'd2);
    var_in = v; var_valid = 1'b1; tick; var_valid = 1'b0;
    cyc = 0;
    while (state == 3'b100 && cyc < 20) begin cyc++; tick; end
    chk({tag, "_lzc_cycles"}, 64'(cyc), 64'd6);
    chk({tag, "_isq"}, 64'(state), 64'd3);
  endtask

  task automatic finish_chan(input string tag);
    invsqrt_done = 1'b1; tick; invsqrt_done = 1'b0;
    chk({tag, "_done_state"}, 64'(state), 64'd5);
    chk({tag, "_done_pulse"}, 64'(done), 64'd1);
    tick;
    chk({tag, "_idle"}, 64'(state), 64'd0);
    chk({tag, "_done_low"}, 64'(done), 64'd0);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [47:0] v;
    int exp_lz;

    rst = 1'b1; start = 0; abort = 0; mean_done = 0; var_valid = 0; invsqrt_done = 0;
    n_pixels = '0; var_in = '0;
    tick; tick;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lzn", 64'(lead_zero_N), 64'd0);
    chk("rst_lzv", 64'(lead_zero_var), 64'd0);
    rst = 1'b0; tick;

    // 1. Basic flow, N=256, var=2^40 -> 47-40 = 7 leading zeros.
    n_pixels = 9'd256; start = 1'b1; tick; start = 1'b0;
    chk("t1_mean", 64'(state), 64'd1);
    chk("t1_lzn", 64'(lead_zero_N), 64'd8);
    chk("t1_busy", 64'(busy), 64'd1);
    mean_done = 1'b1; tick; mean_done = 1'b0;
    chk("t1_var", 64'(state), 64'd2);
    var_in = 48'd1 << 40; var_valid = 1'b1; tick; var_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin chk("t1_lzc", 64'(state), 64'd4); tick; end
    chk("t1_isq", 64'(state), 64'd3);
    chk("t1_lzv", 64'(lead_zero_var), 64'd7);
    tick;
    chk("t1_lzv_hold", 64'(lead_zero_var), 64'd7);
    finish_chan("t1");

    // 2. Clamp on var=1, zero-variance flag on var=0.
    go_to_isq(48'h1, "t2a");
    chk("t2a_lzv", 64'(lead_zero_var), 64'd46);
    chk("t2a_errz", 64'(err_zero_var), 64'd0);
    finish_chan("t2a");
    go_to_isq(48'h0, "t2b");
    chk("t2b_lzv", 64'(lead_zero_var), 64'd46);
    chk("t2b_errz", 64'(err_zero_var), 64'd1);
    finish_chan("t2b");
    chk("t2b_errz_sticky", 64'(err_zero_var), 64'd1);
    n_pixels = 9'd16; start = 1'b1; tick; start = 1'b0;
    chk("t2c_errz_clr", 64'(err_zero_var), 64'd0);
    chk("t2c_lzn", 64'(lead_zero_N), 64'd4);
    abort = 1'b1; tick; abort = 1'b0;
    chk("t2c_abort_idle", 64'(state), 64'd0);

    // 3. Bad pixel counts.
    n_pixels = 9'd100; start = 1'b1; tick; start = 1'b0;
    chk("t3_errn_100", 64'(err_n), 64'd1);
    chk("t3_state_100", 64'(state), 64'd0);
    chk("t3_busy_100", 64'(busy), 64'd0);
    chk("t3_lzn_hold", 64'(lead_zero_N), 64'd4);
    tick;
    chk("t3_errn_pulse", 64'(err_n), 64'd0);
    n_pixels = 9'd0; start = 1'b1; tick; start = 1'b0;
    chk("t3_errn_0", 64'(err_n), 64'd1);
    chk("t3_state_0", 64'(state), 64'd0);

    // 4. Stray inputs in VAR, then abort beating var_valid.
    n_pixels = 9'd64; start = 1'b1; tick; start = 1'b0;
    mean_done = 1'b1; tick; mean_done = 1'b0;
    start = 1'b1; mean_done = 1'b1; invsqrt_done = 1'b1; tick;
    start = 1'b0; mean_done = 1'b0; invsqrt_done = 1'b0;
    chk("t4_stay_var", 64'(state), 64'd2);
    chk("t4_lzn", 64'(lead_zero_N), 64'd6);
    var_in = 48'd5; var_valid = 1'b1; abort = 1'b1; tick;
    var_valid = 1'b0; abort = 1'b0;
    chk("t4_abort_idle", 64'(state), 64'd0);
    chk("t4_abort_nodone", 64'(done), 64'd0);
    chk("t4_abort_busy", 64'(busy), 64'd0);
    chk("t4_lzv_hold", 64'(lead_zero_var), 64'd46);
    tick; tick;
    chk("t4_still_idle", 64'(state), 64'd0);

    // 5. Async reset mid-LZC, then a clean run.
    n_pixels = 9'd256; start = 1'b1; tick; start = 1'b0;
    mean_done = 1'b1; tick; mean_done = 1'b0;
    var_in = 48'd1 << 20; var_valid = 1'b1; tick; var_valid = 1'b0;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_state", 64'(state), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_lzn", 64'(lead_zero_N), 64'd0);
    chk("t5_rst_lzv", 64'(lead_zero_var), 64'd0);
    #1 rst = 1'b0;
    tick;
    go_to_isq(48'd1 << 40, "t5b");
    chk("t5b_lzv", 64'(lead_zero_var), 64'd7);
    finish_chan("t5b");

    // 6. One-hot sweep.
    for (int k = 0; k < 48; k++) begin
      v = 48'd1 << k;
      exp_lz = (47 - k > 46) ? 46 : 47 - k;
      go_to_isq(v, $sformatf("t6_k%0d", k));
      chk($sformatf("t6_lzv_k%0d", k), 64'(lead_zero_var), 64'(exp_lz));
      invsqrt_done = 1'b1; tick; invsqrt_done = 1'b0; tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
